// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared types and constants for the WS2812 serializer
// Purpose: state encoding, LED word width, default 100 MHz timing, small helper.
// Ports: none (package).
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SEND   = 2'd2,
    ST_LATCH  = 2'd3
  } state_t;

  localparam int BITS_PER_LED = 24;

  // Defaults for a 100 MHz clock
  localparam int DEF_NUM_LEDS = 5;
  localparam int DEF_TBIT     = 125;   // 1.25 us bit period
  localparam int DEF_T0H      = 35;    // 0.35 us high for a 0
  localparam int DEF_T1H      = 70;    // 0.70 us high for a 1
  localparam int DEF_TRESET   = 6000;  // 60 us latch gap

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_serializer_if.sv
// rtl/ws2812_serializer_if.sv - engine-side bus of the WS2812 serializer
// Purpose: bundles frame, request and status signals between engine and serializer.
// Ports (signals):
//   GRBSeq  frame, [MSB:MSB-23] = LED0 G7..B0 (master -> slave)
//   Refresh level frame request                (master -> slave)
//   Dout    WS2812 data line                   (slave -> master)
//   Busy    serializer not idle                (slave -> master)
//   Cycle   one-clk frame-done pulse           (slave -> master)
interface ws2812_serializer_if
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS
);

  logic [BITS_PER_LED*NUM_LEDS-1:0] GRBSeq;
  logic                             Refresh;
  logic                             Dout;
  logic                             Busy;
  logic                             Cycle;

  modport master (
    output GRBSeq,
    output Refresh,
    input  Dout,
    input  Busy,
    input  Cycle
  );

  modport slave (
    input  GRBSeq,
    input  Refresh,
    output Dout,
    output Busy,
    output Cycle
  );

endinterface

// File: rtl/ws2812_bit_gen.sv
// rtl/ws2812_bit_gen.sv - NRZ pulse-width generator for one WS2812 bit at a time
// Purpose: bit-period timer and high/low decision for the current bit.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   active      high while bits are being sent; low holds timer and line at 0
//   bit_val     value of the bit currently on the wire
//   dout        registered data line
//   bit_done    high in the last cycle of each bit period
module ws2812_bit_gen
  import ws2812_pkg::*;
#(
  parameter int TBIT = DEF_TBIT,
  parameter int T0H  = DEF_T0H,
  parameter int T1H  = DEF_T1H,
  parameter int TW   = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic bit_val,
  output logic dout,
  output logic bit_done
);

  logic [TW-1:0] timer;

  assign bit_done = active && (timer == TW'(TBIT - 1));

  // Line follows the timer by one clock, so the first high cycle appears
  // one edge after the top enters SEND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
      dout  <= 1'b0;
    end else if (!active) begin
      timer <= '0;
      dout  <= 1'b0;
    end else begin
      dout  <= bit_val ? (timer < TW'(T1H)) : (timer < TW'(T0H));
      timer <= bit_done ? '0 : timer + 1'b1;
    end
  end

endmodule

// File: rtl/ws2812_serializer.sv
// rtl/ws2812_serializer.sv - frame snapshot and WS2812 single-wire serializer
// Purpose: captures the GRB frame on Refresh, sends it MSB first with NRZ
//          pulse-width coding, holds the latch gap, then pulses Cycle.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   bus         slave side of ws2812_serializer_if (GRBSeq, Refresh in;
//               Dout, Busy, Cycle out)
module ws2812_serializer
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int TBIT     = DEF_TBIT,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int TRESET   = DEF_TRESET
) (
  input  logic                clk,
  input  logic                reset,
  ws2812_serializer_if.slave  bus
);

  localparam int NBITS = BITS_PER_LED * NUM_LEDS;
  localparam int CW    = $clog2(NBITS + 1);
  localparam int TW    = $clog2(max_int(TBIT, TRESET));

  state_t           state;
  logic [NBITS-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [TW-1:0]    gap_cnt;
  logic             busy_q;
  logic             cycle_q;
  logic             send_active;
  logic             dout_w;
  logic             bit_done;
  logic             gap_done;

  assign send_active = (state == ST_SEND);
  assign gap_done    = (gap_cnt == TW'(TRESET - 1));

  ws2812_bit_gen #(
    .TBIT (TBIT),
    .T0H  (T0H),
    .T1H  (T1H),
    .TW   (TW)
  ) u_bit_gen (
    .clk      (clk),
    .reset    (reset),
    .active   (send_active),
    .bit_val  (shreg[NBITS-1]),
    .dout     (dout_w),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_RESYNC;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      busy_q  <= 1'b1;
      cycle_q <= 1'b0;
    end else begin
      cycle_q <= 1'b0;
      case (state)
        ST_RESYNC: begin
          if (gap_done) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        ST_IDLE: begin
          if (bus.Refresh) begin
            shreg   <= bus.GRBSeq;
            bit_cnt <= '0;
            gap_cnt <= '0;
            state   <= ST_SEND;
            busy_q  <= 1'b1;
          end
        end

        ST_SEND: begin
          if (bit_done) begin
            shreg <= shreg << 1;
            if (bit_cnt == CW'(NBITS - 1)) begin
              state   <= ST_LATCH;
              bit_cnt <= '0;
              gap_cnt <= '0;
              // A one-cycle latch gap is also its final cycle.
              cycle_q <= (TRESET == 1);
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        ST_LATCH: begin
          if (gap_done) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
            // Registered, so raise it one edge early to land on the final cycle.
            cycle_q <= (gap_cnt == TW'(TRESET - 2));
          end
        end

        default: begin
          state   <= ST_RESYNC;
          gap_cnt <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.Dout  = dout_w;
  assign bus.Busy  = busy_q;
  assign bus.Cycle = cycle_q;

endmodule

// File: tb/tb_ws2812_serializer.sv
// tb/tb_ws2812_serializer.sv - directed self-checking bench for ws2812_serializer
module tb_ws2812_serializer;
  import ws2812_pkg::*;

  localparam int NL     = 5;
  localparam int TBIT   = 12;
  localparam int T0H    = 3;
  localparam int T1H    = 7;
  localparam int TRESET = 60;
  localparam int NB     = 24 * NL;
  localparam int FRAME  = NB * TBIT + TRESET;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ws2812_serializer_if #(.NUM_LEDS(NL)) bus();

  ws2812_serializer #(
    .NUM_LEDS (NL),
    .TBIT     (TBIT),
    .T0H      (T0H),
    .T1H      (T1H),
    .TRESET   (TRESET)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse-width decoder on the data line
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic prev_d    = 1'b0;
  int   rise_cyc  = 0;
  int   nrise     = 0;
  int   nbits     = 0;
  int   bad_width = 0;
  int   ncycle    = 0;
  int   cycle_at  = 0;
  int   rise_at [1024];
  logic bit_at  [1024];

  always @(negedge clk) begin
    int w;
    if (bus.Dout === 1'b1 && prev_d === 1'b0) begin
      if (nrise < 1024) rise_at[nrise] = cyc;
      rise_cyc = cyc;
      nrise++;
    end
    if (bus.Dout === 1'b0 && prev_d === 1'b1) begin
      w = cyc - rise_cyc;
      if (nbits < 1024) bit_at[nbits] = (w == T1H);
      if (w != T0H && w != T1H) bad_width++;
      nbits++;
    end
    if (bus.Cycle === 1'b1) begin
      ncycle++;
      cycle_at = cyc;
    end
    prev_d = bus.Dout;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_busy_low(output int cnt);
    cnt = 0;
    while (bus.Busy === 1'b1 && cnt < 20000) begin
      cnt++;
      step();
    end
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (nrise < target && n < 5000) begin
      n++;
      step();
    end
    if (nrise < target) check_vec("timeout_rise", nrise, target);
  endtask

  task automatic pulse_refresh();
    bus.Refresh = 1'b1;
    step();
    bus.Refresh = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int rb, input int bb, input int badb,
                             input logic [NB-1:0] exp);
    logic [NB-1:0] dec;
    int perr = 0;
    for (int i = 0; i < NB; i++) dec[NB-1-i] = bit_at[bb+i];
    for (int i = 0; i < NB - 1; i++)
      if (rise_at[rb+i+1] - rise_at[rb+i] != TBIT) perr++;
    check_vec({tag, "_bits"}, dec, exp);
    check_vec({tag, "_period"}, perr, 0);
    check_vec({tag, "_width"}, bad_width - badb, 0);
  endtask

  initial begin
    int cnt, rb, bb, badb, cb, n;
    logic [NB-1:0] pat;

    bus.GRBSeq  = '0;
    bus.Refresh = 1'b0;
    reset       = 1'b1;
    step();
    step();

    // 1: reset state and resync gap
    check_vec("rst_dout", bus.Dout, 1'b0);
    check_vec("rst_busy", bus.Busy, 1'b1);
    check_vec("rst_cycle", bus.Cycle, 1'b0);
    reset = 1'b0;
    wait_busy_low(cnt);
    check_vec("resync_len", cnt, TRESET);
    check_vec("resync_rises", nrise, 0);
    check_vec("resync_cycle", ncycle, 0);

    // 2: single frame, LED0 green full on
    pat = 120'hFF0000_000000_000000_000000_000000;
    bus.GRBSeq = pat;
    rb = nrise; bb = nbits; badb = bad_width; cb = ncycle;
    bus.Refresh = 1'b1;
    step();
    bus.Refresh = 1'b0;
    wait_busy_low(cnt);
    check_vec("f1_busy_len", cnt, FRAME);
    check_vec("f1_nbits", nbits - bb, NB);
    check_vec("f1_ncycle", ncycle - cb, 1);
    check_vec("f1_cycle_pos", cycle_at - rise_at[rb], NB * TBIT + TRESET - 2);
    check_frame("f1", rb, bb, badb, pat);

    // 3: frame change after capture is not seen
    pat = {15{8'hAA}};
    bus.GRBSeq = pat;
    rb = nrise; bb = nbits; badb = bad_width;
    pulse_refresh();
    wait_rises(rb + 11);
    bus.GRBSeq = '0;
    wait_busy_low(cnt);
    check_vec("f2_nbits", nbits - bb, NB);
    check_frame("f2", rb, bb, badb, pat);

    // 4: held Refresh, three back-to-back frames
    pat = 120'h123456_789ABC_DEF012_345678_9ABCDE;
    bus.GRBSeq = pat;
    rb = nrise; bb = nbits; badb = bad_width; cb = ncycle;
    bus.Refresh = 1'b1;
    n = 0;
    while (ncycle - cb < 3 && n < 10000) begin
      n++;
      step();
    end
    bus.Refresh = 1'b0;
    wait_busy_low(cnt);
    check_vec("bb_ncycle", ncycle - cb, 3);
    check_vec("bb_nrise", nrise - rb, 3 * NB);
    check_vec("bb_gap01", rise_at[rb+NB] - rise_at[rb], FRAME + 1);
    check_vec("bb_gap12", rise_at[rb+2*NB] - rise_at[rb+NB], FRAME + 1);
    check_frame("bb3", rb + 2 * NB, bb + 2 * NB, badb, pat);

    // 5: asynchronous reset in the high phase of bit 50
    bus.GRBSeq = {NB{1'b1}};
    rb = nrise;
    pulse_refresh();
    wait_rises(rb + 51);
    #1;
    check_vec("pre_rst_dout", bus.Dout, 1'b1);
    reset = 1'b1;
    #1;
    check_vec("async_dout", bus.Dout, 1'b0);
    check_vec("async_busy", bus.Busy, 1'b1);
    step();
    step();
    step();
    rb = nrise; cb = ncycle;
    reset = 1'b0;
    wait_busy_low(cnt);
    check_vec("rst2_len", cnt, TRESET);
    check_vec("rst2_rises", nrise - rb, 0);
    check_vec("rst2_cycle", ncycle - cb, 0);

    // 6: Refresh pulses during SEND and LATCH are ignored
    pat = 120'h0F0F0F_F0F0F0_00FF00_FF00FF_C3C3C3;
    bus.GRBSeq = pat;
    rb = nrise; bb = nbits; badb = bad_width; cb = ncycle;
    pulse_refresh();
    wait_rises(rb + 20);
    pulse_refresh();
    n = 0;
    while (nbits - bb < NB && n < 5000) begin
      n++;
      step();
    end
    repeat (10) step();
    check_vec("latch_busy", bus.Busy, 1'b1);
    pulse_refresh();
    wait_busy_low(cnt);
    repeat (200) step();
    check_vec("ign_nrise", nrise - rb, NB);
    check_vec("ign_ncycle", ncycle - cb, 1);
    check_vec("ign_busy", bus.Busy, 1'b0);
    check_frame("ign", rb, bb, badb, pat);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
